csr_regfile: RTL and testbench

Control/status register file for the LoongArch pipeline, the responder for the write-back stage's CSR access and exception/ertn commit interface. It serves combinational CSR reads, applies masked CSR writes, records exception state on commit, and restores privilege state on ertn. It also runs the architectural timer and a 64-bit stable counter, and raises the interrupt request sampled by decode.

---
 rtl/csr_regfile_if.sv | 30 +++
 rtl/csr_regfile.sv | 194 +++++++++++++++++++
 tb/tb_csr_regfile.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_regfile_if.sv
// CSR access and exception/ertn commit bundle between the write-back stage (master)
// and the control/status register file (slave).
interface csr_regfile_if;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_ex_pc;
    logic [31:0] wb_vaddr;
    logic        ertn_flush;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;

    modport master (
        output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
               wb_ex, wb_ecode, wb_esubcode, wb_ex_pc, wb_vaddr, ertn_flush,
        input  csr_rvalue, ex_entry, ertn_entry
    );

    modport slave (
        input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
               wb_ex, wb_ecode, wb_esubcode, wb_ex_pc, wb_vaddr, ertn_flush,
        output csr_rvalue, ex_entry, ertn_entry
    );
endinterface

// File: rtl/csr_regfile.sv
// LoongArch CSR file: combinational reads, masked writes, exception/ertn commit,
// architectural timer, 64-bit stable counter and interrupt request generation.
module csr_regfile (
    input  logic         clk,
    input  logic         reset,
    csr_regfile_if.slave csr,
    input  logic [7:0]   hw_int_in,
    input  logic         ipi_int_in,
    output logic         has_int,
    output logic [63:0]  stable_counter
);
    localparam logic [13:0] CSR_CRMD   = 14'h00;
    localparam logic [13:0] CSR_PRMD   = 14'h01;
    localparam logic [13:0] CSR_ECFG   = 14'h04;
    localparam logic [13:0] CSR_ESTAT  = 14'h05;
    localparam logic [13:0] CSR_ERA    = 14'h06;
    localparam logic [13:0] CSR_BADV   = 14'h07;
    localparam logic [13:0] CSR_EENTRY = 14'h0C;
    localparam logic [13:0] CSR_SAVE0  = 14'h30;
    localparam logic [13:0] CSR_TID    = 14'h40;
    localparam logic [13:0] CSR_TCFG   = 14'h41;
    localparam logic [13:0] CSR_TVAL   = 14'h42;
    localparam logic [13:0] CSR_TICLR  = 14'h44;

    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;

    function automatic logic [31:0] merge_bits(input logic [31:0] old_val,
                                               input logic [31:0] wmask,
                                               input logic [31:0] wvalue,
                                               input logic [31:0] fmask);
        merge_bits = (old_val & ~(wmask & fmask)) | (wvalue & wmask & fmask);
    endfunction

    logic [31:0] crmd_reg, prmd_reg, ecfg_reg, estat_reg, era_reg, badv_reg, eentry_reg;
    logic [31:0] tid_reg, tcfg_reg, tval_reg;
    logic [31:0] save_reg [4];
    logic        timer_armed_reg;
    logic [63:0] counter_reg;
    logic [31:0] rvalue;

    // Commits pre-empt any CSR write issued in the same cycle.
    logic we_eff;
    assign we_eff = csr.csr_we & ~csr.wb_ex & ~csr.ertn_flush;

    logic crmd_wr, prmd_wr, ecfg_wr, estat_wr, era_wr, badv_wr, eentry_wr;
    logic tid_wr, tcfg_wr, ticlr_hit;
    logic [3:0] save_wr;
    assign crmd_wr   = we_eff && (csr.csr_num == CSR_CRMD);
    assign prmd_wr   = we_eff && (csr.csr_num == CSR_PRMD);
    assign ecfg_wr   = we_eff && (csr.csr_num == CSR_ECFG);
    assign estat_wr  = we_eff && (csr.csr_num == CSR_ESTAT);
    assign era_wr    = we_eff && (csr.csr_num == CSR_ERA);
    assign badv_wr   = we_eff && (csr.csr_num == CSR_BADV);
    assign eentry_wr = we_eff && (csr.csr_num == CSR_EENTRY);
    assign tid_wr    = we_eff && (csr.csr_num == CSR_TID);
    assign tcfg_wr   = we_eff && (csr.csr_num == CSR_TCFG);
    assign ticlr_hit = we_eff && (csr.csr_num == CSR_TICLR)
                       && csr.csr_wmask[0] && csr.csr_wvalue[0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_save_wr
            assign save_wr[gi] = we_eff && (csr.csr_num == CSR_SAVE0 + 14'(gi));
        end
    endgenerate

    logic [31:0] tcfg_wdata;
    logic        timer_fire;
    assign tcfg_wdata = merge_bits(tcfg_reg, csr.csr_wmask, csr.csr_wvalue, 32'hFFFF_FFFF);
    assign timer_fire = timer_armed_reg && !tcfg_wr && (tval_reg == 32'h0);

    always_ff @(posedge clk) begin
        if (reset) begin
            crmd_reg <= 32'h8;
            prmd_reg <= 32'h0;
        end else if (csr.wb_ex) begin
            prmd_reg[2:0] <= crmd_reg[2:0];
            crmd_reg[2:0] <= 3'b000;
        end else if (csr.ertn_flush) begin
            crmd_reg[2:0] <= prmd_reg[2:0];
        end else begin
            if (crmd_wr) crmd_reg <= merge_bits(crmd_reg, csr.csr_wmask, csr.csr_wvalue, 32'h1FF);
            if (prmd_wr) prmd_reg <= merge_bits(prmd_reg, csr.csr_wmask, csr.csr_wvalue, 32'h7);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            era_reg  <= 32'h0;
            badv_reg <= 32'h0;
        end else if (csr.wb_ex) begin
            era_reg <= csr.wb_ex_pc;
            if (csr.wb_ecode == ECODE_ADEF)     badv_reg <= csr.wb_ex_pc;
            else if (csr.wb_ecode == ECODE_ALE) badv_reg <= csr.wb_vaddr;
        end else begin
            if (era_wr)  era_reg  <= merge_bits(era_reg,  csr.csr_wmask, csr.csr_wvalue, 32'hFFFF_FFFF);
            if (badv_wr) badv_reg <= merge_bits(badv_reg, csr.csr_wmask, csr.csr_wvalue, 32'hFFFF_FFFF);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ecfg_reg   <= 32'h0;
            eentry_reg <= 32'h0;
            tid_reg    <= 32'h0;
            for (int i = 0; i < 4; i++) save_reg[i] <= 32'h0;
        end else begin
            if (ecfg_wr)   ecfg_reg   <= merge_bits(ecfg_reg, csr.csr_wmask, csr.csr_wvalue, 32'h1BFF);
            if (eentry_wr) eentry_reg <= merge_bits(eentry_reg, csr.csr_wmask, csr.csr_wvalue, 32'hFFFF_FFC0);
            if (tid_wr)    tid_reg    <= merge_bits(tid_reg, csr.csr_wmask, csr.csr_wvalue, 32'hFFFF_FFFF);
            for (int i = 0; i < 4; i++) begin
                if (save_wr[i])
                    save_reg[i] <= merge_bits(save_reg[i], csr.csr_wmask, csr.csr_wvalue, 32'hFFFF_FFFF);
            end
        end
    end

    // Interrupt lines are sampled into IS every cycle; only the two SW bits are writable.
    always_ff @(posedge clk) begin
        if (reset) begin
            estat_reg <= 32'h0;
        end else begin
            estat_reg[9:2] <= hw_int_in;
            estat_reg[10]  <= 1'b0;
            estat_reg[12]  <= ipi_int_in;
            if (timer_fire)     estat_reg[11] <= 1'b1;
            else if (ticlr_hit) estat_reg[11] <= 1'b0;
            if (csr.wb_ex) begin
                estat_reg[21:16] <= csr.wb_ecode;
                estat_reg[30:22] <= csr.wb_esubcode;
            end
            if (estat_wr)
                estat_reg[1:0] <= (estat_reg[1:0] & ~csr.csr_wmask[1:0])
                                  | (csr.csr_wvalue[1:0] & csr.csr_wmask[1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tcfg_reg        <= 32'h0;
            tval_reg        <= 32'h0;
            timer_armed_reg <= 1'b0;
        end else if (tcfg_wr) begin
            tcfg_reg <= tcfg_wdata;
            if (tcfg_wdata[0]) begin
                tval_reg        <= {tcfg_wdata[31:2], 2'b00};
                timer_armed_reg <= 1'b1;
            end else begin
                timer_armed_reg <= 1'b0;
            end
        end else if (timer_armed_reg && (tval_reg != 32'h0)) begin
            tval_reg <= tval_reg - 32'h1;
        end else if (timer_fire) begin
            if (tcfg_reg[1]) tval_reg        <= {tcfg_reg[31:2], 2'b00};
            else             timer_armed_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) counter_reg <= 64'h0;
        else       counter_reg <= counter_reg + 64'h1;
    end

    always_comb begin
        rvalue = 32'h0;
        case (csr.csr_num)
            CSR_CRMD:   rvalue = crmd_reg;
            CSR_PRMD:   rvalue = prmd_reg;
            CSR_ECFG:   rvalue = ecfg_reg;
            CSR_ESTAT:  rvalue = estat_reg;
            CSR_ERA:    rvalue = era_reg;
            CSR_BADV:   rvalue = badv_reg;
            CSR_EENTRY: rvalue = eentry_reg;
            14'h30:     rvalue = save_reg[0];
            14'h31:     rvalue = save_reg[1];
            14'h32:     rvalue = save_reg[2];
            14'h33:     rvalue = save_reg[3];
            CSR_TID:    rvalue = tid_reg;
            CSR_TCFG:   rvalue = tcfg_reg;
            CSR_TVAL:   rvalue = tval_reg;
            default:    rvalue = 32'h0;
        endcase
    end

    // The read strobe carries no information: reads decode csr_num directly.
    logic unused_ok;
    assign unused_ok = csr.csr_re;

    assign csr.csr_rvalue  = rvalue;
    assign csr.ex_entry    = eentry_reg;
    assign csr.ertn_entry  = era_reg;
    assign has_int         = crmd_reg[2] & (|(estat_reg[12:0] & ecfg_reg[12:0]));
    assign stable_counter  = counter_reg;
endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: expected values go through a scoreboard queue and
// are popped and asserted against the DUT when the observation point is reached.
module tb_csr_regfile;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic        has_int;
    logic [63:0] stable_counter;

    csr_regfile_if bus ();

    csr_regfile dut (
        .clk            (clk),
        .reset          (reset),
        .csr            (bus),
        .hw_int_in      (hw_int_in),
        .ipi_int_in     (ipi_int_in),
        .has_int        (has_int),
        .stable_counter (stable_counter)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] exp_q [$];
    string       tag_q [$];
    logic [63:0] cyc;

    // Independent cycle count since the last reset edge.
    always @(posedge clk) begin
        if (reset) cyc <= 64'h0;
        else       cyc <= cyc + 64'h1;
    end

    task automatic expect_val(input string tag, input logic [63:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic observe(input logic [63:0] obs);
        logic [63:0] e;
        string       t;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %h with no expected value", obs);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", t, obs, e);
        end
        $display("[%0t] %s observed %h expected %h", $time, t, obs, e);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        expect_val(tag, exp_v);
        observe(obs);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [13:0] num, input logic [31:0] exp_v);
        expect_val(tag, {32'h0, exp_v});
        bus.csr_num = num;
        #1;
        observe({32'h0, bus.csr_rvalue});
    endtask

    task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
        bus.csr_we     = 1'b1;
        bus.csr_num    = num;
        bus.csr_wmask  = mask;
        bus.csr_wvalue = val;
        tick();
        bus.csr_we     = 1'b0;
    endtask

    task automatic do_ex(input logic [5:0] ecode, input logic [31:0] pc,
                         input logic [31:0] vaddr, input logic [31:0] entry_exp);
        bus.wb_ex       = 1'b1;
        bus.wb_ecode    = ecode;
        bus.wb_esubcode = 9'h0;
        bus.wb_ex_pc    = pc;
        bus.wb_vaddr    = vaddr;
        #1;
        chk("ex_entry_redirect", {32'h0, bus.ex_entry}, {32'h0, entry_exp});
        tick();
        bus.wb_ex = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        hw_int_in      = 8'h0;
        ipi_int_in     = 1'b0;
        bus.csr_re     = 1'b0;
        bus.csr_num    = 14'h0;
        bus.csr_we     = 1'b0;
        bus.csr_wmask  = 32'h0;
        bus.csr_wvalue = 32'h0;
        bus.wb_ex      = 1'b0;
        bus.wb_ecode   = 6'h0;
        bus.wb_esubcode= 9'h0;
        bus.wb_ex_pc   = 32'h0;
        bus.wb_vaddr   = 32'h0;
        bus.ertn_flush = 1'b0;
        tick();
        tick();

        // Reset state
        rd("reset_crmd", 14'h00, 32'h8);
        chk("reset_has_int", {63'h0, has_int}, 64'h0);
        chk("reset_ex_entry", {32'h0, bus.ex_entry}, 64'h0);
        chk("reset_ertn_entry", {32'h0, bus.ertn_entry}, 64'h0);
        chk("reset_counter", stable_counter, 64'h0);
        reset = 1'b0;
        tick(); tick(); tick();
        chk("counter_after_3", stable_counter, 64'h3);

        // Masked write merge
        wr(14'h32, 32'hFFFF_FFFF, 32'hAAAA_AAAA);
        wr(14'h32, 32'h0000_FFFF, 32'h1234_5678);
        rd("save2_merge", 14'h32, 32'hAAAA_5678);

        // Exception with ALE, then ertn
        wr(14'h00, 32'hFFFF_FFFF, 32'h7);
        rd("crmd_write", 14'h00, 32'h7);
        wr(14'h0C, 32'hFFFF_FFFF, 32'h1C00_8000);
        do_ex(6'h09, 32'h1C00_0100, 32'h0000_0003, 32'h1C00_8000);
        rd("ale_era", 14'h06, 32'h1C00_0100);
        rd("ale_badv", 14'h07, 32'h0000_0003);
        rd("ale_prmd", 14'h01, 32'h7);
        rd("ale_crmd", 14'h00, 32'h0);
        rd("ale_estat", 14'h05, 32'h0009_0000);
        bus.ertn_flush = 1'b1;
        #1;
        chk("ertn_entry_redirect", {32'h0, bus.ertn_entry}, {32'h0, 32'h1C00_0100});
        tick();
        bus.ertn_flush = 1'b0;
        rd("ertn_crmd", 14'h00, 32'h7);

        // ADEF, then exception and ertn each racing a CSR write
        do_ex(6'h08, 32'h1C00_0200, 32'hDEAD_BEEF, 32'h1C00_8000);
        rd("adef_badv", 14'h07, 32'h1C00_0200);
        bus.csr_we = 1'b1; bus.csr_num = 14'h30; bus.csr_wmask = 32'hFFFF_FFFF; bus.csr_wvalue = 32'h55;
        do_ex(6'h03, 32'h1C00_0300, 32'h0000_1234, 32'h1C00_8000);
        bus.csr_we = 1'b0;
        rd("ex_drops_we_save0", 14'h30, 32'h0);
        rd("ex_we_era", 14'h06, 32'h1C00_0300);
        rd("other_ecode_badv", 14'h07, 32'h1C00_0200);
        bus.csr_we = 1'b1; bus.csr_num = 14'h31; bus.csr_wvalue = 32'h66;
        bus.ertn_flush = 1'b1;
        tick();
        bus.csr_we = 1'b0; bus.ertn_flush = 1'b0;
        rd("ertn_drops_we_save1", 14'h31, 32'h0);

        // One-shot timer
        wr(14'h00, 32'hFFFF_FFFF, 32'h4);
        wr(14'h04, 32'hFFFF_FFFF, 32'h800);
        wr(14'h41, 32'hFFFF_FFFF, 32'h5);
        for (int i = 4; i >= 0; i--) begin
            rd("oneshot_tval", 14'h42, 32'(i));
            chk("oneshot_no_int", {63'h0, has_int}, 64'h0);
            if (i > 0) tick();
        end
        tick();
        rd("oneshot_fire_estat", 14'h05, 32'h0003_0800);
        chk("oneshot_has_int", {63'h0, has_int}, 64'h1);
        wr(14'h44, 32'h1, 32'h1);
        rd("ticlr_clears", 14'h05, 32'h0003_0000);
        chk("ticlr_has_int", {63'h0, has_int}, 64'h0);
        for (int i = 0; i < 8; i++) tick();
        rd("oneshot_no_recur", 14'h05, 32'h0003_0000);
        rd("ticlr_reads_zero", 14'h44, 32'h0);

        // Periodic timer, TICLR racing a fire
        wr(14'h41, 32'hFFFF_FFFF, 32'h7);
        for (int i = 0; i < 4; i++) tick();
        rd("periodic_tval0", 14'h42, 32'h0);
        tick();
        rd("periodic_fire1", 14'h05, 32'h0003_0800);
        rd("periodic_reload", 14'h42, 32'h4);
        wr(14'h44, 32'h1, 32'h1);
        rd("periodic_cleared", 14'h05, 32'h0003_0000);
        tick(); tick(); tick();
        rd("periodic_tval0_again", 14'h42, 32'h0);
        wr(14'h44, 32'h1, 32'h1);
        rd("fire_beats_ticlr", 14'h05, 32'h0003_0800);
        rd("periodic_reload2", 14'h42, 32'h4);
        wr(14'h41, 32'hFFFF_FFFF, 32'h0);
        tick();
        rd("disabled_tval_hold", 14'h42, 32'h4);
        wr(14'h42, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd("tval_read_only", 14'h42, 32'h4);
        wr(14'h44, 32'h1, 32'h1);

        // Hardware and IPI interrupt paths
        wr(14'h04, 32'hFFFF_FFFF, 32'h4);
        hw_int_in = 8'h01;
        #1;
        chk("hw_int_lag", {63'h0, has_int}, 64'h0);
        tick();
        chk("hw_int_has_int", {63'h0, has_int}, 64'h1);
        rd("hw_int_estat", 14'h05, 32'h0003_0004);
        hw_int_in = 8'h00;
        tick();
        chk("hw_int_drop", {63'h0, has_int}, 64'h0);
        wr(14'h04, 32'hFFFF_FFFF, 32'h1000);
        ipi_int_in = 1'b1;
        tick();
        chk("ipi_has_int", {63'h0, has_int}, 64'h1);
        ipi_int_in = 1'b0;
        tick();

        // Field masks and unmapped space
        wr(14'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd("ecfg_mask", 14'h04, 32'h0000_1BFF);
        wr(14'h05, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd("estat_sw_mask", 14'h05, 32'h0003_0003);
        chk("sw_int_has_int", {63'h0, has_int}, 64'h1);
        wr(14'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd("crmd_mask", 14'h00, 32'h0000_01FF);
        wr(14'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd("prmd_mask", 14'h01, 32'h7);
        wr(14'h0C, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("eentry_mask", {32'h0, bus.ex_entry}, {32'h0, 32'hFFFF_FFC0});
        wr(14'h99, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd("unmapped_0x99", 14'h99, 32'h0);
        wr(14'h40, 32'hFFFF_FFFF, 32'hCAFE_0001);
        rd("tid_rw", 14'h40, 32'hCAFE_0001);
        chk("counter_tracks", stable_counter, cyc);

        // Reset during a countdown
        wr(14'h41, 32'hFFFF_FFFF, 32'h5);
        tick(); tick();
        reset = 1'b1;
        tick();
        rd("rst_tval", 14'h42, 32'h0);
        rd("rst_tcfg", 14'h41, 32'h0);
        rd("rst_crmd", 14'h00, 32'h8);
        chk("rst_ex_entry", {32'h0, bus.ex_entry}, 64'h0);
        chk("rst_ertn_entry", {32'h0, bus.ertn_entry}, 64'h0);
        chk("rst_has_int", {63'h0, has_int}, 64'h0);
        chk("rst_counter", stable_counter, 64'h0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rd("rst_timer_disarmed", 14'h05, 32'h0);
        rd("rst_tval_idle", 14'h42, 32'h0);
        chk("counter_after_rst", stable_counter, 64'h8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
